// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-port bundle for mem_port_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dp_req;
  logic              dp_we;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_gnt;
  logic              dp_done;
  logic [DATA_W-1:0] dp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  dp_req, dp_we, dp_addr, dp_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dp_gnt, dp_done, dp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dp_req, dp_we, dp_addr, dp_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dp_gnt, dp_done, dp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / data-port arbiter for the single-ported memory.
// MEM_ARB_RR_EN selects round-robin; default is fixed DP > IF.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic              cur_dp;
  logic              cur_we;
  logic              last_dp;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dp_rdata_q;

  logic arb;
  logic pick_dp;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dp_rdata  = dp_rdata_q;

  always_comb begin
    nxt           = state;
    arb           = 1'b0;
    pick_dp       = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.dp_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dp_done   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        arb = bus.if_req | bus.dp_req;
`ifdef MEM_ARB_RR_EN
        // on contention the previous loser goes next
        pick_dp = bus.dp_req
                & (~bus.if_req | ~last_dp);
`else
        pick_dp = bus.dp_req;
`endif
        nxt = arb ? ISSUE : IDLE;
        if (state == DONE) begin
          bus.if_rvalid = ~cur_dp;
          bus.dp_done   = cur_dp;
        end
      end
      ISSUE: begin
        bus.if_gnt = ~cur_dp;
        bus.dp_gnt = cur_dp;
        bus.mem_en = 1'b1;
        bus.mem_we = cur_we;
        bus.busy   = 1'b1;
        nxt        = WAIT;
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (cnt == 4'd0) nxt = DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_dp     <= 1'b0;
      cur_we     <= 1'b0;
      last_dp    <= 1'b1;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dp_rdata_q <= '0;
    end else begin
      state <= nxt;
      if (arb) begin
        cur_dp  <= pick_dp;
        cur_we  <= pick_dp & bus.dp_we;
        addr_q  <= pick_dp ? bus.dp_addr
                           : bus.if_addr;
        wdata_q <= pick_dp ? bus.dp_wdata
                           : '0;
      end
      if (state == ISSUE) begin
        cnt     <= 4'(MEM_LAT - 1);
        last_dp <= cur_dp;
      end
      if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!cur_we) begin
          if (cur_dp) dp_rdata_q <= bus.mem_rdata;
          else        if_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  a_last_winner: assert property (
    @(posedge clk) disable iff (!rst_n)
    state == ISSUE |=> last_dp == $past(cur_dp));

  a_one_pulse: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0({bus.if_gnt, bus.dp_gnt,
              bus.if_rvalid, bus.dp_done}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter at MEM_LAT 2, 1 and 15.
// Define MEM_ARB_RR_EN here too when building the round-robin variant.
module tb_mem_port_arbiter;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L2 = 15;

  localparam int K_IG = 0;
  localparam int K_DG = 1;
  localparam int K_RV = 2;
  localparam int K_DD = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if b0 ();
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L2))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
    logic        we;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit zchk  = 1'b0;
  bit fin   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [15:0] mem [logic [15:0]];
  int          rem [3];
  logic [15:0] pa  [3];

  function automatic logic [15:0] rd(logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == 16'h0010) return 16'hF01A;
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] mstep(
    int i, int lat, logic en, logic we,
    logic [15:0] a, logic [15:0] wd);
    logic v;
    v = 1'b0;
    if (en) begin
      rem[i] = lat;
      pa[i]  = a;
      if (we) mem[a] = wd;
    end else if (rem[i] > 0) begin
      rem[i] = rem[i] - 1;
      v      = (rem[i] == 0);
    end
    return v ? rd(pa[i]) : 16'hDEAD;
  endfunction

  always @(negedge clk) begin
    b0.mem_rdata = mstep(0, L0, b0.mem_en, b0.mem_we,
                         b0.mem_addr, b0.mem_wdata);
    b1.mem_rdata = mstep(1, L1, b1.mem_en, b1.mem_we,
                         b1.mem_addr, b1.mem_wdata);
    b2.mem_rdata = mstep(2, L2, b2.mem_en, b2.mem_we,
                         b2.mem_addr, b2.mem_wdata);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string nm, bit ok,
                     logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push(int i, int k, int c,
                      logic [15:0] a, logic [15:0] d,
                      logic we);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.a    = a;
    e.d    = d;
    e.we   = we;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(int i, output bit have, output ev_t e);
    have = 1'b0;
    e    = '{default: 0};
    if (qsize(i) > 0) begin
      have = 1'b1;
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  int bcnt     [3];
  bit fin_done [3];

  task automatic mon(int i, int lat,
                     logic ig, logic dg, logic rv, logic dd,
                     logic en, logic we, logic bz,
                     logic [15:0] ma, logic [15:0] mw,
                     logic [15:0] ir, logic [15:0] dr);
    int  k;
    bit  have;
    bit  ok;
    ev_t e;
    logic [79:0] act;
    logic [79:0] exp;
    if (zchk)
      chk($sformatf("reset_zero_u%0d", i),
          {ig, dg, rv, dd, en, we, bz, ma, mw, ir, dr} == '0,
          {ig, dg, rv, dd, en, we, bz, ma, mw, ir, dr}, '0);
    if (!rst_n) begin
      bcnt[i] = 0;
    end else if (bz) begin
      bcnt[i]++;
    end else if (bcnt[i] > 0) begin
      chk($sformatf("busy_len_u%0d", i),
          bcnt[i] == lat + 1, bcnt[i], lat + 1);
      bcnt[i] = 0;
    end
    if (en | ig | dg)
      chk($sformatf("mem_en_gnt_u%0d", i),
          en == (ig | dg), {en, ig, dg}, {ig | dg, ig, dg});
    if (ig | dg | rv | dd) begin
      chk($sformatf("onehot_u%0d", i),
          $onehot({ig, dg, rv, dd}), {ig, dg, rv, dd}, 4'b0001);
      k = ig ? K_IG : dg ? K_DG : rv ? K_RV : K_DD;
      pop(i, have, e);
      chk($sformatf("expected_u%0d", i), have, k, 80'hFF);
      if (have) begin
        chk($sformatf("ev_kind_cyc_u%0d", i),
            k == e.kind && cyc == e.cyc,
            {k, cyc}, {e.kind, e.cyc});
        case (k)
          K_IG: begin
            ok  = ma == e.a && !we;
            act = {we, ma};
            exp = {1'b0, e.a};
          end
          K_DG: begin
            ok  = ma == e.a && we == e.we
                && (!e.we || mw == e.d);
            act = {we, ma, mw};
            exp = {e.we, e.a, e.d};
          end
          K_RV: begin
            ok  = ir == e.d;
            act = ir;
            exp = e.d;
          end
          default: begin
            ok  = dr == e.d;
            act = dr;
            exp = e.d;
          end
        endcase
        chk($sformatf("ev_data_u%0d_k%0d", i, k), ok, act, exp);
      end
    end
    if (fin && !fin_done[i]) begin
      fin_done[i] = 1'b1;
      chk($sformatf("sb_drain_u%0d", i),
          qsize(i) == 0, qsize(i), 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, L0, b0.if_gnt, b0.dp_gnt, b0.if_rvalid, b0.dp_done,
        b0.mem_en, b0.mem_we, b0.busy, b0.mem_addr,
        b0.mem_wdata, b0.if_rdata, b0.dp_rdata);
    mon(1, L1, b1.if_gnt, b1.dp_gnt, b1.if_rvalid, b1.dp_done,
        b1.mem_en, b1.mem_we, b1.busy, b1.mem_addr,
        b1.mem_wdata, b1.if_rdata, b1.dp_rdata);
    mon(2, L2, b2.if_gnt, b2.dp_gnt, b2.if_rvalid, b2.dp_done,
        b2.mem_en, b2.mem_we, b2.busy, b2.mem_addr,
        b2.mem_wdata, b2.if_rdata, b2.dp_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic go(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic if_op(logic [15:0] a, logic [15:0] exp);
    int t;
    t = cyc;
    b0.if_req  = 1'b1;
    b0.if_addr = a;
    push(0, K_IG, t + 1, a, 16'h0, 1'b0);
    push(0, K_RV, t + 4, 16'h0, exp, 1'b0);
    go(1);
    b0.if_req = 1'b0;
    go(5);
  endtask

  task automatic dp_op(logic we, logic [15:0] a,
                       logic [15:0] wd, logic [15:0] exp);
    int t;
    t = cyc;
    b0.dp_req   = 1'b1;
    b0.dp_we    = we;
    b0.dp_addr  = a;
    b0.dp_wdata = wd;
    push(0, K_DG, t + 1, a, wd, we);
    push(0, K_DD, t + 4, 16'h0, exp, 1'b0);
    go(1);
    b0.dp_req = 1'b0;
    b0.dp_we  = 1'b0;
    go(5);
  endtask

  task automatic zero_inputs();
    b0.if_req = 0; b0.if_addr = 0; b0.dp_req = 0;
    b0.dp_we = 0; b0.dp_addr = 0; b0.dp_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.dp_req = 0;
    b1.dp_we = 0; b1.dp_addr = 0; b1.dp_wdata = 0;
    b2.if_req = 0; b2.if_addr = 0; b2.dp_req = 0;
    b2.dp_we = 0; b2.dp_addr = 0; b2.dp_wdata = 0;
  endtask

  initial begin
    int t;
    zero_inputs();
    #1;
    rst_n = 1'b0;
    zchk  = 1'b1;
    go(3);
    zchk  = 1'b0;
    rst_n = 1'b1;
    go(1);

    // single fetch, store, load, store keeping dp_rdata
    if_op(16'h0010, 16'hF01A);
    dp_op(1'b1, 16'h0200, 16'hBEEF, 16'h0000);
    dp_op(1'b0, 16'h0200, 16'h0000, 16'hBEEF);
    dp_op(1'b1, 16'h0300, 16'h1234, 16'hBEEF);

    // one contended pair
    t = cyc;
    b0.if_req  = 1'b1;
    b0.if_addr = 16'h0040;
    b0.dp_req  = 1'b1;
    b0.dp_addr = 16'h0200;
`ifdef MEM_ARB_RR_EN
    push(0, K_IG, t + 1, 16'h0040, 16'h0, 1'b0);
    push(0, K_RV, t + 4, 16'h0, 16'hA5E5, 1'b0);
    push(0, K_DG, t + 5, 16'h0200, 16'h0, 1'b0);
    push(0, K_DD, t + 8, 16'h0, 16'hBEEF, 1'b0);
    go(1);
    b0.if_req = 1'b0;
    go(4);
    b0.dp_req = 1'b0;
`else
    push(0, K_DG, t + 1, 16'h0200, 16'h0, 1'b0);
    push(0, K_DD, t + 4, 16'h0, 16'hBEEF, 1'b0);
    push(0, K_IG, t + 5, 16'h0040, 16'h0, 1'b0);
    push(0, K_RV, t + 8, 16'h0, 16'hA5E5, 1'b0);
    go(1);
    b0.dp_req = 1'b0;
    go(4);
    b0.if_req = 1'b0;
`endif
    go(5);

    // both held for three accesses
    t = cyc;
    b0.if_req  = 1'b1;
    b0.if_addr = 16'h0040;
    b0.dp_req  = 1'b1;
    b0.dp_addr = 16'h0300;
`ifdef MEM_ARB_RR_EN
    push(0, K_IG, t + 1, 16'h0040, 16'h0, 1'b0);
    push(0, K_RV, t + 4, 16'h0, 16'hA5E5, 1'b0);
    push(0, K_DG, t + 5, 16'h0300, 16'h0, 1'b0);
    push(0, K_DD, t + 8, 16'h0, 16'h1234, 1'b0);
    push(0, K_IG, t + 9, 16'h0040, 16'h0, 1'b0);
    push(0, K_RV, t + 12, 16'h0, 16'hA5E5, 1'b0);
    go(9);
    b0.dp_req = 1'b0;
    b0.if_req = 1'b0;
`else
    for (int j = 0; j < 3; j++) begin
      push(0, K_DG, t + 1 + 4 * j, 16'h0300, 16'h0, 1'b0);
      push(0, K_DD, t + 4 + 4 * j, 16'h0, 16'h1234, 1'b0);
    end
    push(0, K_IG, t + 13, 16'h0040, 16'h0, 1'b0);
    push(0, K_RV, t + 16, 16'h0, 16'hA5E5, 1'b0);
    go(9);
    b0.dp_req = 1'b0;
    go(4);
    b0.if_req = 1'b0;
`endif
    go(5);

    // fetch req held past gnt: back-to-back with new address
    t = cyc;
    b0.if_req  = 1'b1;
    b0.if_addr = 16'h0020;
    push(0, K_IG, t + 1, 16'h0020, 16'h0, 1'b0);
    push(0, K_RV, t + 4, 16'h0, 16'hA585, 1'b0);
    push(0, K_IG, t + 5, 16'h0021, 16'h0, 1'b0);
    push(0, K_RV, t + 8, 16'h0, 16'hA584, 1'b0);
    go(1);
    b0.if_addr = 16'h0021;
    go(4);
    b0.if_req = 1'b0;
    go(5);

    // dp_req pulsed during WAIT only: must be dropped
    t = cyc;
    b0.if_req  = 1'b1;
    b0.if_addr = 16'h0070;
    push(0, K_IG, t + 1, 16'h0070, 16'h0, 1'b0);
    push(0, K_RV, t + 4, 16'h0, 16'hA5D5, 1'b0);
    go(1);
    b0.if_req = 1'b0;
    go(1);
    b0.dp_req  = 1'b1;
    b0.dp_addr = 16'h0300;
    go(1);
    b0.dp_req = 1'b0;
    go(4);

    // reset during WAIT of a load: no dp_done afterwards
    t = cyc;
    b0.dp_req  = 1'b1;
    b0.dp_we   = 1'b0;
    b0.dp_addr = 16'h0200;
    push(0, K_DG, t + 1, 16'h0200, 16'h0, 1'b0);
    go(1);
    b0.dp_req = 1'b0;
    go(1);
    rst_n = 1'b0;
    zchk  = 1'b1;
    go(2);
    zchk  = 1'b0;
    rst_n = 1'b1;
    go(3);
    dp_op(1'b0, 16'h0300, 16'h0000, 16'h1234);

    // latency extremes
    t = cyc;
    b1.if_req  = 1'b1;
    b1.if_addr = 16'h0050;
    b2.if_req  = 1'b1;
    b2.if_addr = 16'h0060;
    push(1, K_IG, t + 1, 16'h0050, 16'h0, 1'b0);
    push(1, K_RV, t + 3, 16'h0, 16'hA5F5, 1'b0);
    push(2, K_IG, t + 1, 16'h0060, 16'h0, 1'b0);
    push(2, K_RV, t + 17, 16'h0, 16'hA5C5, 1'b0);
    go(1);
    b1.if_req = 1'b0;
    b2.if_req = 1'b0;
    go(20);

    fin = 1'b1;
    go(1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
